// File: rtl/maindec_pipe_if.sv
// maindec_pipe_if: D-stage decode inputs and per-stage control outputs of maindec_pipe.
interface maindec_pipe_if #(
    parameter int STAGES = 3
);
    logic [31:0]           instr_d;
    logic                  valid_d;
    logic                  stall;
    logic                  flush_e;
    logic                  hazard_d;
    logic [12*STAGES-1:0]  ctrl_pipe;
    logic [5*STAGES-1:0]   writereg_pipe;
    logic [STAGES-1:0]     valid_pipe;
    logic [STAGES-1:0]     illegal_pipe;

    modport master (
        output instr_d, valid_d, stall, flush_e,
        input  hazard_d, ctrl_pipe, writereg_pipe, valid_pipe, illegal_pipe
    );

    modport slave (
        input  instr_d, valid_d, stall, flush_e,
        output hazard_d, ctrl_pipe, writereg_pipe, valid_pipe, illegal_pipe
    );
endinterface

// File: rtl/maindec_pipe.sv
// maindec_pipe: pipelined MIPS-32 main decoder with stall, E-flush and load-use bubble.
// The branch/jump group decodes only when MAINDEC_BRANCH_EN is defined; otherwise it is illegal.
module maindec_pipe #(
    parameter int STAGES = 3
) (
    input logic           clk,
    input logic           rst,
    maindec_pipe_if.slave bus
);
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [11:0] ctrl_d;
    logic        ill_d;
    logic [4:0]  wr_d;
    logic        take;

    assign op    = bus.instr_d[31:26];
    assign rs    = bus.instr_d[25:21];
    assign rt    = bus.instr_d[20:16];
    assign rd    = bus.instr_d[15:11];
    assign funct = bus.instr_d[5:0];

    always_comb begin
        ctrl_d = '0;
        ill_d  = 1'b0;
        case (op)
            6'b000000:
                case (funct)
                    6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
                    6'b010000, 6'b010010, 6'b100000, 6'b100001, 6'b100010, 6'b100011,
                    6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011: ctrl_d = 12'h060;
                    6'b010001, 6'b010011, 6'b011000, 6'b011001, 6'b011010, 6'b011011: ctrl_d = 12'h010;
`ifdef MAINDEC_BRANCH_EN
                    6'b001000: ctrl_d = 12'h00A;
                    6'b001001: ctrl_d = 12'h06A;
`endif
                    default: ill_d = 1'b1;
                endcase
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b001100, 6'b001101, 6'b001110, 6'b001111: ctrl_d = 12'h0A0;
            6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: ctrl_d = 12'hCA0;
            6'b101000, 6'b101001, 6'b101011: ctrl_d = 12'h680;
`ifdef MAINDEC_BRANCH_EN
            6'b000100, 6'b000101, 6'b000110, 6'b000111: ctrl_d = 12'h100;
            6'b000001:
                case (rt)
                    5'b00000, 5'b00001: ctrl_d = 12'h100;
                    5'b10000, 5'b10001: ctrl_d = 12'h121;
                    default: ill_d = 1'b1;
                endcase
            6'b000010: ctrl_d = 12'h008;
            6'b000011: ctrl_d = 12'h02C;
`endif
            default: ill_d = 1'b1;
        endcase
        // All-zero word is the canonical nop, not an SLL that writes $0.
        if (bus.instr_d == 32'd0) begin
            ctrl_d = '0;
            ill_d  = 1'b0;
        end
    end

    assign wr_d = !ctrl_d[5] ? 5'd0 : (ctrl_d[2] || ctrl_d[0]) ? 5'd31 : ctrl_d[6] ? rd : rt;

    assign bus.hazard_d = bus.valid_d && bus.valid_pipe[0] && bus.ctrl_pipe[11] &&
                          (bus.writereg_pipe[4:0] != 5'd0) &&
                          (bus.writereg_pipe[4:0] == rs || bus.writereg_pipe[4:0] == rt);

    assign take = bus.valid_d && !bus.flush_e && !bus.hazard_d;

    // Stage word layout: {illegal, valid, writereg[4:0], ctrl[11:0]}.
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [18:0] d;
        logic [18:0] q;
        if (s == 0) begin : g_head
            assign d = take ? {ill_d, 1'b1, wr_d, ctrl_d} : '0;
        end else begin : g_tail
            assign d = g_stage[s-1].q;
        end
        always_ff @(posedge clk)
            if (rst) q <= '0;
            else if (!bus.stall || (s == 0 && bus.flush_e)) q <= d;
        assign bus.ctrl_pipe[12*s +: 12]    = q[11:0];
        assign bus.writereg_pipe[5*s +: 5]  = q[16:12];
        assign bus.valid_pipe[s]            = q[17];
        assign bus.illegal_pipe[s]          = q[18];
    end
endmodule

// File: doc/maindec_pipe.md
# maindec_pipe

Pipelined, parametrised main decoder for the MIPS-32 core. It decodes the D-stage instruction into the 12-bit control bundle and registers it through `STAGES` post-decode pipeline stages (E, M, W, …), with stall, E-flush and a self-inserted load-use bubble. It sits between the D-stage instruction register and the datapath stage registers, and replaces a purely combinational decoder plus per-stage control flops.

## Interface
- `STAGES`, default 3: number of registered control stages after D; legal range 1..4. Stage 0 is E.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_d`  in  32  D-stage instruction word.
- `valid_d`  in  1  `instr_d` is a real instruction.
- `stall`  in  1  freeze all stages.
- `flush_e`  in  1  load a bubble into stage 0.
- `hazard_d`  out  1  combinational load-use hazard; upstream holds D while it is high.
- `ctrl_pipe`  out  12*STAGES  control bundle per stage; stage k occupies bits [12k+11:12k]. Bundle bit order, 11..0: memtoreg, memen, memwrite, branch, alusrc, regdst, regwrite, hilowrite, jump, jal, jr, bal.
- `writereg_pipe`  out  5*STAGES  destination register per stage.
- `valid_pipe`  out  STAGES  stage holds a real instruction.
- `illegal_pipe`  out  STAGES  stage holds an undecodable instruction.

## Operation
- **Decode (combinational, internal).** Any op/funct not listed below gives bundle 0 and illegal=1. `instr_d==0` gives bundle 0 and illegal=0 (nop).
  - I-type ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI: 0x0A0.
  - LB, LBU, LH, LHU, LW: 0xCA0.
  - SB, SH, SW: 0x680.
  - R-type (op 0) AND, OR, XOR, NOR, SLL, SRL, SRA, SLLV, SRLV, SRAV, MFHI, MFLO, ADD, ADDU, SUB, SUBU, SLT, SLTU: 0x060.
  - R-type MTHI, MTLO, MULT, MULTU, DIV, DIVU: 0x010.
  - Branch/jump group (see Configuration):
    - BEQ, BNE, BLEZ, BGTZ: 0x100.
    - REGIMM (op 000001) rt=00000 or 00001: 0x100.
    - REGIMM rt=10000 or 10001: 0x121.
    - J: 0x008.
    - JAL: 0x02C.
    - JR: 0x00A.
    - JALR: 0x06A.
- **writereg.** 31 if jal or bal; else rd if regdst; else rt. Forced to 0 when regwrite=0.
- **Invalid slots.** When valid_d=0, stage 0 receives a bubble: bundle 0, writereg 0, valid 0, illegal 0.
- **Hazard.** `hazard_d` = valid_d & valid_pipe[0] & memtoreg_e & (writereg_e != 0) & (writereg_e == rs_d | writereg_e == rt_d). The rt comparison is always made, so the check is conservative.
- **Stage update per edge, highest priority first:**
  - rst: every stage gets a bubble.
  - stall=1: all stages hold. Exception: if flush_e=1, stage 0 gets a bubble and stages ≥1 still hold.
  - Otherwise stage k (k≥1) loads stage k-1.
  - Stage 0 loads a bubble if flush_e or hazard_d; else it loads the decoded D instruction.

## Timing
- Reset value of every output register: 0. `hazard_d` is 0 after reset because valid_pipe[0]=0.
- Latency: a D instruction appears in stage k k+1 edges after capture, absent stalls.
- `hazard_d` is high for exactly one cycle per load-use pair, absent stall. The next cycle the load sits in stage 1 and the dependent instruction decodes.
- When stall and hazard_d are both high, nothing advances and no bubble is inserted.
- Asserting rst mid-stall or mid-hazard clears all stages on that edge.

## Configuration
- `MAINDEC_BRANCH_EN` defined: the branch/jump group decodes as listed.
- `MAINDEC_BRANCH_EN` undefined: every branch/jump opcode and funct (BEQ, BNE, BLEZ, BGTZ, REGIMM, J, JAL, JR, JALR) decodes as illegal with bundle 0. All other behaviour is unchanged.

## Test plan
- Reset with STAGES=3, then feed `0x20080005` (addi $t0,$zero,5) for one cycle: ctrl stage0=0x0A0, writereg 8, valid 1. It appears in stage 2 two edges later.
- `0x8D090000` (lw $t1) then `0x01285020` (add $t2,$t1,$t0): hazard_d=1 for one cycle, stage 0 gets a bubble. The add then reaches stage 0 with ctrl 0x060, writereg 10.
- `0x0C000010` (jal): with the macro, stage0 ctrl 0x02C, writereg 31. Without the macro: ctrl 0, illegal 1.
- `0x01090018` (mult): ctrl 0x010, writereg 0. Opcode 111111: illegal_pipe[0]=1, ctrl 0.
- stall=1 for 2 cycles with a full pipe: all outputs are unchanged. stall=1 with flush_e=1: only stage 0 clears.
- `0x04110003` (bgezal, macro on): ctrl 0x121, writereg 31. `instr_d=0`: ctrl 0, illegal 0, valid 1.
